// File: rtl/cpu_io_pkg.sv
// Shared types for the CPU output port: word type and transmit FSM states.
package cpu_io_pkg;

  localparam int OUTWIDTH = 25;

  typedef logic [OUTWIDTH-1:0] out_word_t;

  typedef enum logic [0:0] {
    TX_EMPTY = 1'b0,
    TX_VALID = 1'b1
  } tx_state_t;

  // Occupancy seen by software: buffered entries plus the presented word.
  function automatic logic [4:0] port_level(input logic [3:0] fifo_count, input logic out_valid);
    port_level = {1'b0, fifo_count} + {4'b0000, out_valid};
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Single-clock synchronous FIFO with combinational head, registered count and full.
module out_fifo
  import cpu_io_pkg::*;
#(
  parameter int DATAWIDTH = OUTWIDTH,
  parameter int DEPTH     = 8,
  parameter int PTRWIDTH  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] rdata,
  output logic [PTRWIDTH:0]    count,
  output logic                 full
);

  localparam logic [PTRWIDTH:0] C_DEPTH = (PTRWIDTH+1)'(DEPTH);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [PTRWIDTH-1:0]  r_wr_ptr;
  logic [PTRWIDTH-1:0]  r_rd_ptr;
  logic [PTRWIDTH:0]    r_count;
  logic                 r_full;

  logic                 w_do_push;
  logic                 w_do_pop;
  logic [PTRWIDTH:0]    w_count_nxt;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_do_pop  = pop && (r_count != {(PTRWIDTH+1){1'b0}});
  assign w_do_push = push && (!r_full || w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + (PTRWIDTH+1)'(1);
      2'b01:   w_count_nxt = r_count - (PTRWIDTH+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= {PTRWIDTH{1'b0}};
      r_rd_ptr <= {PTRWIDTH{1'b0}};
      r_count  <= {(PTRWIDTH+1){1'b0}};
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTRWIDTH'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTRWIDTH'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
    end
  end

  // Storage is cleared on reset so the head can never carry X.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATAWIDTH{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = r_full;

endmodule

// File: rtl/out_port_tx.sv
// Transmit side of the CPU output port: FIFO-buffered words presented on outFlag/out
// with a ready handshake, one-cycle bypass when the FIFO is empty, sticky overflow.
module out_port_tx
  import cpu_io_pkg::*;
#(
  parameter int DATAWIDTH = OUTWIDTH,
  parameter int DEPTH     = 8,
  parameter int PTRWIDTH  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wrEn,
  input  logic [DATAWIDTH-1:0] wrData,
  output logic                 full,
  input  logic                 outReady,
  output logic                 outFlag,
  output logic [DATAWIDTH-1:0] out,
  output logic [PTRWIDTH+1:0]  level,
  output logic                 overflow
);

  tx_state_t            r_state;
  logic [DATAWIDTH-1:0] r_out;
  logic                 r_overflow;

  tx_state_t            w_state_nxt;
  logic [DATAWIDTH-1:0] w_out_nxt;
  logic                 w_pop;
  logic                 w_slot_free;
  logic                 w_fifo_empty;
  logic                 w_fifo_rd;
  logic                 w_bypass;
  logic                 w_push_req;
  logic                 w_fifo_wr;
  logic                 w_drop;
  logic                 w_fifo_full;
  logic [PTRWIDTH:0]    w_fifo_count;
  logic [DATAWIDTH-1:0] w_fifo_head;

  assign w_pop        = (r_state == TX_VALID) && outReady;
  assign w_slot_free  = (r_state == TX_EMPTY) || w_pop;
  assign w_fifo_empty = (w_fifo_count == {(PTRWIDTH+1){1'b0}});
  assign w_fifo_rd    = w_slot_free && !w_fifo_empty;
  // Bypass only with an empty FIFO so a new word never overtakes buffered ones.
  assign w_bypass     = w_slot_free && w_fifo_empty && wrEn;
  assign w_push_req   = wrEn && !w_bypass;
  assign w_fifo_wr    = w_push_req && (!w_fifo_full || w_fifo_rd);
  assign w_drop       = w_push_req && w_fifo_full && !w_fifo_rd;

  out_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH),
    .PTRWIDTH  (PTRWIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_fifo_wr),
    .wdata (wrData),
    .pop   (w_fifo_rd),
    .rdata (w_fifo_head),
    .count (w_fifo_count),
    .full  (w_fifo_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    case (r_state)
      TX_EMPTY: begin
        if (w_fifo_rd) begin
          w_state_nxt = TX_VALID;
          w_out_nxt   = w_fifo_head;
        end else if (w_bypass) begin
          w_state_nxt = TX_VALID;
          w_out_nxt   = wrData;
        end else begin
          w_state_nxt = TX_EMPTY;
        end
      end
      TX_VALID: begin
        if (!w_pop) begin
          w_state_nxt = TX_VALID;
        end else if (w_fifo_rd) begin
          w_state_nxt = TX_VALID;
          w_out_nxt   = w_fifo_head;
        end else if (w_bypass) begin
          w_state_nxt = TX_VALID;
          w_out_nxt   = wrData;
        end else begin
          w_state_nxt = TX_EMPTY;
        end
      end
      default: begin
        w_state_nxt = TX_EMPTY;
        w_out_nxt   = {DATAWIDTH{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= TX_EMPTY;
      r_out      <= {DATAWIDTH{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign outFlag  = (r_state == TX_VALID);
  assign out      = r_out;
  assign full     = w_fifo_full;
  assign overflow = r_overflow;
  assign level    = {1'b0, w_fifo_count} + {{(PTRWIDTH+1){1'b0}}, outFlag};

endmodule

// File: tb/tb_out_port_tx.sv
// Self-checking bench for out_port_tx against a queue model of all held words.
module tb_out_port_tx;

  localparam int DW    = 25;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          wrEn;
  logic [DW-1:0] wrData;
  logic          outReady;
  logic          full;
  logic          outFlag;
  logic [DW-1:0] out;
  logic [PW+1:0] level;
  logic          overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Model: every word the port holds, oldest first (presented word at index 0).
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last;
  logic          m_ovf;
  logic [DW-1:0] rx[$];
  logic [DW-1:0] sent[$];

  out_port_tx #(.DATAWIDTH(DW), .DEPTH(DEPTH), .PTRWIDTH(PW)) dut (
    .clock    (clock),
    .reset    (reset),
    .wrEn     (wrEn),
    .wrData   (wrData),
    .full     (full),
    .outReady (outReady),
    .outFlag  (outFlag),
    .out      (out),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] m_vec();
    int n;
    n = m_q.size();
    m_vec = {(n > 0), (n > 0) ? m_q[0] : m_last, 5'(n), (n == DEPTH + 1), m_ovf};
  endfunction

  function automatic logic [32:0] dut_vec();
    dut_vec = {outFlag, out, level, full, overflow};
  endfunction

  // Drive one edge, log any handshake, and advance the model by the same edge.
  task automatic step(input logic rst_n, input logic wr, input logic [DW-1:0] d, input logic rdy);
    int   n;
    logic pop;
    reset = rst_n; wrEn = wr; wrData = d; outReady = rdy;
    if (rst_n && outFlag && rdy) rx.push_back(out);
    @(posedge clock);
    if (!rst_n) begin
      m_q.delete(); m_last = '0; m_ovf = 1'b0;
    end else begin
      n = m_q.size();
      pop = (n > 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (wr) begin
        if (n - int'(pop) <= DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
    #1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (outFlag && cyc < 40) begin
      step(1'b1, 1'b0, DW'($urandom), 1'b1);
      cyc++;
      vectors++;
      if (dut_vec() !== m_vec()) begin
        miscompares++;
        $display("FAIL %s drain cyc %0d: got %h want %h", name, cyc, dut_vec(), m_vec());
      end
    end
    vectors++;
    if (outFlag !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drain timeout: outFlag=%b want 0", name, outFlag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wrEn = 1'b0; wrData = '0; outReady = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 25'h1555555, 1'b1);
    vectors++;
    if (dut_vec() !== 33'h0) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", dut_vec(), 33'h0);
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b1, 25'h0000ABC, 1'b0);
    vectors++;
    if ({outFlag, out, level} !== {1'b1, 25'h0000ABC, 5'd1}) begin
      miscompares++;
      $display("FAIL single_latency: got %b %h %0d want 1 0000abc 1", outFlag, out, level);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, DW'($urandom), 1'b0);
      vectors++;
      if ({outFlag, out, level} !== {1'b1, 25'h0000ABC, 5'd1}) begin
        miscompares++;
        $display("FAIL single_hold %0d: got %b %h %0d want 1 0000abc 1", i, outFlag, out, level);
      end
    end
    step(1'b1, 1'b0, DW'($urandom), 1'b1);
    vectors++;
    if ({outFlag, level} !== {1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL single_pop: got flag %b level %0d want 0 0", outFlag, level);
    end
  endtask

  task automatic test_stream();
    int flag_cycles = 0;
    rx.delete();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, (i <= 15), (i <= 15) ? DW'(i) : DW'($urandom), 1'b1);
      if (outFlag) flag_cycles++;
      vectors++;
      if (dut_vec() !== m_vec() || full !== 1'b0 || level > 5'd1) begin
        miscompares++;
        $display("FAIL stream cyc %0d: got %h want %h", i, dut_vec(), m_vec());
      end
    end
    vectors++;
    if (flag_cycles != 15 || rx.size() != 15) begin
      miscompares++;
      $display("FAIL stream_count: got %0d flag cycles %0d pops want 15 15", flag_cycles, rx.size());
    end
    for (int k = 0; k < rx.size(); k++) begin
      vectors++;
      if (rx[k] !== DW'(k + 1)) begin
        miscompares++;
        $display("FAIL stream_order %0d: got %h want %h", k, rx[k], DW'(k + 1));
      end
    end
  endtask

  task automatic test_fill();
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, DW'(32'h10 + i), 1'b0);
      vectors++;
      if (dut_vec() !== m_vec()) begin
        miscompares++;
        $display("FAIL fill cyc %0d: got %h want %h", i, dut_vec(), m_vec());
      end
    end
    vectors++;
    if ({out, full, level, overflow} !== {25'h10, 1'b1, 5'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_full: got out %h full %b level %0d ovf %b want 10 1 9 0", out, full, level, overflow);
    end
    step(1'b1, 1'b1, 25'h19, 1'b0);
    vectors++;
    if ({overflow, level, out} !== {1'b1, 5'd9, 25'h10}) begin
      miscompares++;
      $display("FAIL fill_drop: got ovf %b level %0d out %h want 1 9 10", overflow, level, out);
    end
    rx.delete();
    drain("fill");
    vectors++;
    if (rx.size() != 9 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_drain: got %0d words ovf %b want 9 1", rx.size(), overflow);
    end
    for (int k = 0; k < rx.size(); k++) begin
      vectors++;
      if (rx[k] !== DW'(32'h10 + k)) begin
        miscompares++;
        $display("FAIL fill_order %0d: got %h want %h", k, rx[k], DW'(32'h10 + k));
      end
    end
  endtask

  task automatic test_full_pop();
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, DW'(32'h30 + i), 1'b0);
    rx.delete();
    step(1'b1, 1'b1, 25'h20, 1'b1);
    vectors++;
    if ({overflow, full, level} !== {1'b0, 1'b1, 5'd9}) begin
      miscompares++;
      $display("FAIL fullpop_accept: got ovf %b full %b level %0d want 0 1 9", overflow, full, level);
    end
    drain("fullpop");
    vectors++;
    if (rx.size() != 10 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_count: got %0d words ovf %b want 10 0", rx.size(), overflow);
    end
    for (int k = 0; k < rx.size(); k++) begin
      vectors++;
      if (rx[k] !== ((k < 9) ? DW'(32'h30 + k) : 25'h20)) begin
        miscompares++;
        $display("FAIL fullpop_order %0d: got %h", k, rx[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
    step(1'b1, 1'b1, 25'h1FFFFFF, 1'b0);
    step(1'b1, 1'b1, 25'h1FFFFFF, 1'b0);
    step(1'b1, 1'b1, 25'h1FFFFFF, 1'b0);
    step(1'b1, 1'b1, 25'h1FFFFFF, 1'b0);
    step(1'b1, 1'b1, 25'h1FFFFFF, 1'b0);
    step(1'b0, 1'b1, 25'h1FFFFFF, 1'b1);
    vectors++;
    if ({outFlag, out, level, full, overflow} !== 33'h0) begin
      miscompares++;
      $display("FAIL resetmid: got %h want 0", dut_vec());
    end
    step(1'b1, 1'b1, 25'h7, 1'b0);
    vectors++;
    if ({outFlag, out, level} !== {1'b1, 25'h7, 5'd1}) begin
      miscompares++;
      $display("FAIL resetmid_write: got %b %h %0d want 1 7 1", outFlag, out, level);
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    logic wr;
    logic [DW-1:0] d;
    step(1'b0, 1'b0, '0, 1'b0);
    sent.delete(); rx.delete();
    while (sent.size() < 40 && cyc < 400) begin
      wr = (m_q.size() < DEPTH);
      d  = DW'($urandom);
      step(1'b1, wr, d, cyc[0]);
      if (wr) sent.push_back(d);
      cyc++;
      vectors++;
      if (dut_vec() !== m_vec()) begin
        miscompares++;
        $display("FAIL wrap cyc %0d: got %h want %h", cyc, dut_vec(), m_vec());
      end
    end
    drain("wrap");
    vectors++;
    if (rx.size() != 40 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d words ovf %b want 40 0", rx.size(), overflow);
    end
    for (int k = 0; k < rx.size() && k < sent.size(); k++) begin
      vectors++;
      if (rx[k] !== sent[k]) begin
        miscompares++;
        $display("FAIL wrap_order %0d: got %h want %h", k, rx[k], sent[k]);
      end
    end
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), DW'($urandom),
           (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      vectors++;
      if (dut_vec() !== m_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_full_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/out_port_tx.md
Name: out_port_tx

Overview:
- Transmit side of the CPU output port.
- Accepts 25-bit result words from the CPU writeback stage and buffers them in a small FIFO.
- Presents each word to the consumer (bench file logger or external sink) on outFlag/out, with a ready handshake.
- Prevents output words being lost when the consumer stalls while the pipeline keeps retiring output instructions.

Parameters:
- DATAWIDTH, 25, width of out / wrData.
- DEPTH, 8, FIFO entries, excluding the output register; power of two.
- PTRWIDTH, 3, log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- wrEn  in  1  CPU writeback presents an output word this cycle.
- wrData  in  DATAWIDTH  output word from CPU.
- full  out  1  FIFO holds DEPTH entries.
- outReady  in  1  consumer accepts the presented word this cycle.
- outFlag  out  1  out holds a valid word.
- out  out  DATAWIDTH  presented word, registered.
- level  out  PTRWIDTH+2  FIFO count plus outFlag (0..DEPTH+1).
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Reset (reset==0 at a clock edge): outFlag=0, out=0, full=0, level=0, overflow=0, FIFO pointers and count=0. Reset mid-transfer discards all buffered words. No partial state is kept.
- Transfer: occurs on an edge where outFlag==1 and outReady==1 ("pop").
- Stability: while outFlag==1 and outReady==0, out and outFlag hold unchanged.
- Output register FSM, states EMPTY and VALID:
  - EMPTY -> VALID when a word is available: FIFO non-empty, or wrEn with the FIFO empty (bypass).
  - VALID -> VALID on pop if another word is available. Back-to-back pops are sustained, one word per cycle.
  - VALID -> EMPTY on pop when nothing is available.
  - VALID stays VALID with no change when there is no pop.
- Latency: wrEn at edge N, with FIFO empty and the output register empty or popping at N, gives outFlag=1 and out=wrData after edge N. That is one cycle, bypassing FIFO storage.
- Ordering: strict FIFO. The bypass is taken only when the FIFO is empty, so words never overtake.
- Output register refill source: the FIFO head when the FIFO is non-empty, otherwise wrData via bypass.
- Write acceptance:
  - accepted if count<DEPTH, or if count==DEPTH and a FIFO read occurs on the same edge (refill on pop).
  - otherwise the word is dropped and overflow is set to 1; it stays 1 until reset.
- Simultaneous FIFO read and write: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is PTRWIDTH+1 bits, range 0..DEPTH. full = (count==DEPTH), registered with count.
- level = count + outFlag, combinational from registers.
- wrData is ignored when wrEn==0. outReady is ignored when outFlag==0.
- No X may propagate onto out. Unwritten FIFO entries are never presented.

Decomposition:
- Package cpu_io_pkg holds:
  - OUTWIDTH=25
  - typedef out_word_t (logic [OUTWIDTH-1:0])
  - enum tx_state_t {TX_EMPTY, TX_VALID}
- One natural sub-module: out_fifo. It is a synchronous single-clock FIFO with push, pop, head data, count and full, parameterised by DATAWIDTH and DEPTH, and uses the same active-low synchronous reset.
- The FSM, bypass mux and overflow flag live in out_port_tx.

Test Plan:
1. Single word: reset low for 1 edge, then high. wrEn=1, wrData=25'h0000ABC at edge 1, outReady=0. Required: after edge 1, outFlag=1, out=0000ABC, level=1. It holds for 5 edges. outReady=1 at edge 7 -> outFlag=0 after edge 7.
2. Stream: 15 words 1..15 on consecutive edges, outReady=1 throughout. Required: exactly 15 outFlag cycles, values 1..15 in order, each one edge after its write. full never asserted. level never exceeds 1.
3. Backpressure and fill: outReady=0, write 9 words 0x10..0x18. Required: out=0x10, full=1 after the 9th write, level=9. A 10th write 0x19 is dropped and overflow=1. Then outReady=1: required pops are 0x10..0x18, one per cycle; 0x19 never appears; overflow stays 1.
4. Write on full with pop: FIFO full, outReady=1 and wrEn=1 with 0x20 on the same edge. Required: accepted, overflow stays 0, full stays 1, 0x20 appears after the 8 buffered words.
5. Reset mid-operation: 5 words buffered, outFlag=1, drive reset=0 for one edge. Required after that edge: outFlag=0, out=0, level=0, full=0, overflow=0. A next write 0x7 appears with 1-cycle latency.
6. Pointer wrap: 40 words with outReady toggling 1/0 every cycle. Required: all 40 words received in order and no overflow.
